alarm_flag_clearer: RTL and testbench
=====================================

Name: alarm_flag_clearer

Overview:
- Service end of the sticky set-only flag latches: reads up to N latched alarm flags (Q outputs of the set-only flip-flops).
- Presents one pending flag at a time to a consumer (display/alert logic) over a valid/ack handshake.
- After acknowledgement, drives that latch's clear (its reset input) with a timed pulse.
- Sits between the flag latch bank and the alarm display/controller; it is the only thing that clears flags besides global reset.

Parameters:
- N_FLAGS, 4, number of flag channels (1..16).
- ID_W, 2, width of event_id; must satisfy 2^ID_W >= N_FLAGS.
- CLR_CYCLES, 2, clear pulse length in clock cycles (>=1).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; all state and outputs to reset values immediately.
- flag_in  in  N_FLAGS  latched flag levels; bit i high = alarm i pending.
- event_ack  in  1  consumer acknowledge; sampled only while event_valid=1.
- event_valid  out  1  an event is being presented.
- event_id  out  ID_W  index of presented flag; held stable while event_valid=1.
- clear_out  out  N_FLAGS  per-channel clear pulse to flag latch resets; at most one bit high at a time.
- busy  out  1  high in any state other than IDLE.
- served_cnt  out  8  count of acknowledged-and-cleared events; saturates at 255.

Behaviour:
- Reset values: event_valid=0, event_id=0, clear_out=0, busy=0, served_cnt=0, state=IDLE, rr_ptr=0. All outputs are registered.
- States: IDLE, PRESENT, CLEAR, SETTLE.
- IDLE:
  - If any flag_in bit is high, select the first set bit searching upward from rr_ptr, wrapping at N_FLAGS-1 to 0.
  - Load event_id with the selected index; go to PRESENT. event_valid rises 1 cycle after flag_in is seen high.
  - If no bit is high, stay in IDLE.
- PRESENT:
  - event_valid=1; event_id is held.
  - If flag_in[event_id]=0 (flag cleared externally), drop event_valid next cycle, return to IDLE; no clear pulse, served_cnt unchanged, rr_ptr unchanged.
  - Else if event_ack=1: next cycle event_valid=0, clear_out[event_id]=1, load clear counter, go to CLEAR.
  - Ack and external flag drop in the same cycle: the drop wins.
  - Acks arriving while event_valid=0 are ignored.
- CLEAR:
  - clear_out[event_id] stays high for exactly CLR_CYCLES cycles, then goes low.
  - On the last clear cycle: go to SETTLE; served_cnt += 1 (saturate at 255); rr_ptr = event_id+1, wrapping to 0 past N_FLAGS-1.
- SETTLE:
  - One cycle with all outputs idle except busy=1, giving the latch time to show Q=0. Then go to IDLE.
  - A flag that re-sets during or after its clear is re-presented later through normal arbitration, never suppressed.
- Fairness: round-robin, so a continuously pending flag is served within N_FLAGS service cycles.
- Reset asserted mid-operation (any state): immediate return to reset values, clear_out drops asynchronously, no event is counted.
- Flags set while busy remain pending in their latches; nothing is lost.

Test Plan:
- Reset, then flag_in=0010 -> event_valid high 1 cycle later with event_id=1. Ack -> clear_out=0010 for 2 cycles. Bench latch clears. served_cnt=1, busy low after SETTLE.
- flag_in=1011, ack every event immediately -> events presented in order 0,1,3. Each is followed by a clear pulse on the matching bit only. served_cnt=3.
- Present id=2, hold event_ack=0 for 20 cycles -> event_valid and event_id=2 stable for all 20 cycles, clear_out=0. Then ack -> normal clear.
- In PRESENT with id=0, force flag_in[0]=0 in the same cycle as ack=1 -> no clear pulse, back to IDLE, served_cnt unchanged.
- Assert reset during the second cycle of CLEAR on channel 3 -> clear_out=0 immediately, event_valid=0, served_cnt keeps its pre-event value.
- Keep flag 0 continuously re-set for 300 ack/clear cycles -> served_cnt saturates at 255 with no wrap. With flag 2 also pending, events alternate 0,2,0,2.

Source files
------------

// File: rtl/alarm_flag_clearer.sv
// Services sticky alarm flag latches one at a time: round-robin pick, present over valid/ack,
// then pulse the latch clear for CLR_CYCLES cycles and count the served event.
module alarm_flag_clearer #(
    parameter int N_FLAGS    = 4,
    parameter int ID_W       = 2,
    parameter int CLR_CYCLES = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N_FLAGS-1:0] flag_in,
    input  logic               event_ack,
    output logic               event_valid,
    output logic [ID_W-1:0]    event_id,
    output logic [N_FLAGS-1:0] clear_out,
    output logic               busy,
    output logic [7:0]         served_cnt
);
    localparam int CNT_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_CLEAR, S_SETTLE} state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    w_rr_ptr_nx;
    logic [ID_W-1:0]    r_event_id;
    logic [ID_W-1:0]    w_event_id_nx;
    logic [ID_W-1:0]    w_sel_id;
    logic               w_sel_found;
    logic [ID_W:0]      w_idx;
    logic [CNT_W-1:0]   r_clr_cnt;
    logic [CNT_W-1:0]   w_clr_cnt_nx;
    logic [7:0]         r_served_cnt;
    logic [7:0]         w_served_cnt_nx;
    logic               r_event_valid;
    logic               r_busy;
    logic [N_FLAGS-1:0] r_clear_out;
    logic [N_FLAGS-1:0] w_id_mask;

    assign w_id_mask = N_FLAGS'(1) << r_event_id;

    // First pending flag at or above the round-robin pointer, wrapping at N_FLAGS-1.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_id    = '0;
        w_idx       = '0;
        for (int k = 0; k < N_FLAGS; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
            if (w_idx >= (ID_W+1)'(N_FLAGS)) begin
                w_idx = w_idx - (ID_W+1)'(N_FLAGS);
            end
            if (!w_sel_found && flag_in[w_idx[ID_W-1:0]]) begin
                w_sel_found = 1'b1;
                w_sel_id    = w_idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        w_state_nx      = r_state;
        w_event_id_nx   = r_event_id;
        w_rr_ptr_nx     = r_rr_ptr;
        w_clr_cnt_nx    = r_clr_cnt;
        w_served_cnt_nx = r_served_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_sel_found) begin
                    w_state_nx    = S_PRESENT;
                    w_event_id_nx = w_sel_id;
                end
            end
            S_PRESENT: begin
                // An externally dropped flag takes priority over a simultaneous ack.
                if (!flag_in[r_event_id]) begin
                    w_state_nx = S_IDLE;
                end else if (event_ack) begin
                    w_state_nx   = S_CLEAR;
                    w_clr_cnt_nx = CNT_W'(CLR_CYCLES - 1);
                end
            end
            S_CLEAR: begin
                if (r_clr_cnt == '0) begin
                    w_state_nx      = S_SETTLE;
                    w_served_cnt_nx = (r_served_cnt == 8'hFF) ? r_served_cnt : r_served_cnt + 8'd1;
                    w_rr_ptr_nx     = (r_event_id == ID_W'(N_FLAGS - 1)) ? '0 : r_event_id + 1'b1;
                end else begin
                    w_clr_cnt_nx = r_clr_cnt - 1'b1;
                end
            end
            S_SETTLE: w_state_nx = S_IDLE;
            default:  w_state_nx = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_rr_ptr      <= '0;
            r_event_id    <= '0;
            r_clr_cnt     <= '0;
            r_served_cnt  <= '0;
            r_event_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_clear_out   <= '0;
        end else begin
            r_state       <= w_state_nx;
            r_rr_ptr      <= w_rr_ptr_nx;
            r_event_id    <= w_event_id_nx;
            r_clr_cnt     <= w_clr_cnt_nx;
            r_served_cnt  <= w_served_cnt_nx;
            r_event_valid <= (w_state_nx == S_PRESENT);
            r_busy        <= (w_state_nx != S_IDLE);
            r_clear_out   <= (w_state_nx == S_CLEAR) ? w_id_mask : '0;
        end
    end

    assign event_valid = r_event_valid;
    assign event_id    = r_event_id;
    assign clear_out   = r_clear_out;
    assign busy        = r_busy;
    assign served_cnt  = r_served_cnt;
endmodule

// File: tb/tb_alarm_flag_clearer.sv
// Scoreboard bench for alarm_flag_clearer: a set-only latch bank model feeds the DUT,
// a reference model predicts the service order, and a monitor checks what the DUT presents.
module tb_alarm_flag_clearer;
    localparam int N   = 4;
    localparam int CLR = 2;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] flag_in;
    logic         event_ack = 1'b0;
    logic         event_valid;
    logic [1:0]   event_id;
    logic [N-1:0] clear_out;
    logic         busy;
    logic [7:0]   served_cnt;

    logic [N-1:0] lat = '0;
    logic [N-1:0] set_req = '0;
    logic [N-1:0] drop_req = '0;

    typedef struct {
        int id;
        int cnt;
        bit clr;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_ptr = 0;
    int   m_cnt = 0;

    alarm_flag_clearer #(.N_FLAGS(N), .ID_W(2), .CLR_CYCLES(CLR)) dut (
        .clock      (clock),
        .reset      (reset),
        .flag_in    (flag_in),
        .event_ack  (event_ack),
        .event_valid(event_valid),
        .event_id   (event_id),
        .clear_out  (clear_out),
        .busy       (busy),
        .served_cnt (served_cnt)
    );

    always #5 clock = ~clock;

    // Latch bank: set by stimulus, reset by the DUT clear pulse or global reset.
    assign flag_in = lat & ~drop_req;
    always @(posedge clock or posedge reset) begin
        if (reset) lat <= '0;
        else       lat <= ((lat & ~clear_out) | set_req) & ~drop_req;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on each presented event and checks the clear pulse.
    exp_t cur;
    bit   prev_v = 1'b0;
    bit   in_clr = 1'b0;
    bit   settle_chk = 1'b0;
    int   clr_len = 0;
    always @(negedge clock) begin
        if (reset) begin
            prev_v = 1'b0; in_clr = 1'b0; settle_chk = 1'b0; clr_len = 0;
        end else begin
            if (settle_chk) begin
                check("busy_after_settle", int'(busy), 0);
                settle_chk = 1'b0;
            end
            if (event_valid && !prev_v) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", 1, 0);
                    cur.id = -1; cur.cnt = -1; cur.clr = 1'b0;
                end else begin
                    cur = exp_q.pop_front();
                    check("event_id", int'(event_id), cur.id);
                    check("served_cnt_before", int'(served_cnt), cur.cnt);
                    check("busy_present", int'(busy), 1);
                end
            end
            if (event_valid) begin
                check("held_id", int'(event_id), cur.id);
                check("no_clear_while_valid", int'(clear_out), 0);
            end
            if (!event_valid && prev_v)
                check("clear_at_ack", int'(clear_out), cur.clr ? (1 << cur.id) : 0);
            if (clear_out != '0) begin
                if (!in_clr) begin in_clr = 1'b1; clr_len = 0; end
                clr_len++;
                check("clear_mask", int'(clear_out), 1 << cur.id);
            end else if (in_clr) begin
                in_clr = 1'b0;
                check("clear_len", clr_len, CLR);
                check("settle_busy", int'(busy), 1);
                check("settle_valid", int'(event_valid), 0);
                settle_chk = 1'b1;
            end
            prev_v = event_valid;
        end
    end

    task automatic wait_valid(input bit level, input string name);
        int i = 0;
        while (event_valid !== level && i < 100) begin @(negedge clock); i++; end
        check(name, int'(event_valid === level), 1);
    endtask

    task automatic wait_idle();
        int i = 0;
        while (!(busy == 1'b0 && event_valid == 1'b0 && lat == '0 && clear_out == '0) && i < 100) begin
            @(negedge clock); i++;
        end
        check("reach_idle", int'(busy == 1'b0 && lat == '0), 1);
    endtask

    task automatic do_reset();
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
        reset = 1'b1; event_ack = 1'b0; set_req = '0; drop_req = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        m_cnt = 0; m_ptr = 0;
        @(negedge clock);
    endtask

    // Reference: serve pending flags round-robin from the pointer until none remain.
    task automatic serve(input logic [N-1:0] mask, input int hold, input bit drop);
        logic [N-1:0] p = mask;
        int n = 0;
        int sel;
        exp_t e;
        wait_idle();
        while (p != '0) begin
            sel = -1;
            for (int k = 0; k < N; k++)
                if (sel < 0 && p[(m_ptr + k) % N]) sel = (m_ptr + k) % N;
            p[sel] = 1'b0;
            e.id = sel; e.cnt = m_cnt; e.clr = !drop;
            exp_q.push_back(e);
            n++;
            if (!drop) begin
                m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                m_ptr = (sel + 1) % N;
            end
        end
        set_req = mask;
        event_ack = 1'b1;
        @(negedge clock);
        set_req = '0;
        event_ack = 1'b0;
        check("valid_not_early", int'(event_valid), 0);
        @(negedge clock);
        check("valid_latency", int'(event_valid), 1);
        for (int j = 0; j < n; j++) begin
            wait_valid(1'b1, "wait_present");
            repeat ((hold < 0) ? $urandom_range(0, 3) : hold) @(negedge clock);
            if (drop) drop_req = mask;
            event_ack = 1'b1;
            @(negedge clock);
            event_ack = 1'b0;
            drop_req = '0;
            wait_valid(1'b0, "wait_release");
        end
    endtask

    initial begin
        exp_t e;
        @(negedge clock);
        check("rst_valid", int'(event_valid), 0);
        check("rst_id", int'(event_id), 0);
        check("rst_clear", int'(clear_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_cnt", int'(served_cnt), 0);
        reset = 1'b0;
        @(negedge clock);

        // Reset in the second cycle of a clear on channel 3.
        e.id = 3; e.cnt = 0; e.clr = 1'b1;
        exp_q.push_back(e);
        set_req = 4'b1000;
        @(negedge clock);
        set_req = '0;
        wait_valid(1'b1, "abort_present");
        event_ack = 1'b1;
        @(negedge clock);
        event_ack = 1'b0;
        check("abort_clear_on", int'(clear_out), 8);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("abort_clear_off", int'(clear_out), 0);
        check("abort_valid", int'(event_valid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_cnt", int'(served_cnt), 0);
        @(negedge clock);
        do_reset();

        serve(4'b0010, -1, 1'b0);
        wait_idle();
        check("single_cnt", int'(served_cnt), 1);
        do_reset();

        serve(4'b1011, 0, 1'b0);
        wait_idle();
        check("three_cnt", int'(served_cnt), 3);

        serve(4'b0100, 20, 1'b0);
        serve(4'b0001, 0, 1'b1);
        wait_idle();
        check("drop_cnt", int'(served_cnt), m_cnt);

        for (int r = 0; r < 30; r++)
            serve(4'($urandom_range(1, 15)), -1, 1'b0);

        for (int r = 0; r < 150; r++)
            serve(4'b0101, -1, 1'b0);
        wait_idle();
        check("sat_cnt", int'(served_cnt), 255);
        check("model_cnt", int'(served_cnt), m_cnt);
        check("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
